ram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 8-bit system RAM.
- Requester 0 is the CPU memory path: instruction fetch, LDA/STA/ADD/SUB operand access.
- Requester 1 is the program loader / IO port.
- Fixed priority to requester 0, with a starvation limiter that forces a grant to requester 1 after MAX_WAIT consecutive lost arbitrations. Each transaction runs through a 3-state FSM that drives the RAM and returns an ack.

---
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port system RAM: fixed priority to
// requester 0 with a starvation limiter for requester 1; each access is ACCESS then RESP.
module ram_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          win0, win1;

  // Requester 1 preempts only once it has lost MAX_WAIT decisions in a row.
  assign win1 = req1 && ((wait_cnt_q >= MAX_W) || !req0);
  assign win0 = req0 && !win1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    if (state_q == RESP) begin
      if (owner_q) rdata1_d = ram_rdata;
      else         rdata0_d = ram_rdata;
    end
    case (state_q)
      ACCESS: state_d = RESP;
      default: begin
        // IDLE and RESP both end in a decision edge.
        state_d = IDLE;
        if (win1) begin
          state_d    = ACCESS;
          owner_d    = 1'b1;
          addr_d     = addr1;
          we_d       = we1;
          wdata_d    = wdata1;
          wait_cnt_d = 4'd0;
        end else if (win0) begin
          state_d = ACCESS;
          owner_d = 1'b0;
          addr_d  = addr0;
          we_d    = we0;
          wdata_d = wdata0;
          if (req1 && (wait_cnt_q != 4'hF)) wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    ram_we = 1'b0;
    busy   = (state_q != IDLE);
    if (state_q == ACCESS || state_q == RESP) begin
      gnt0 = !owner_q;
      gnt1 = owner_q;
    end
    if (state_q == ACCESS) ram_we = we_q;
    if (state_q == RESP) begin
      ack0 = !owner_q;
      ack1 = owner_q;
    end
    rdata0 = ack0 ? ram_rdata : rdata0_q;
    rdata1 = ack1 ? ram_rdata : rdata1_q;
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a synchronous-read RAM model behind it.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, ack0, gnt1, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, busy;
  logic       pl_we;
  logic [7:0] pl_addr, pl_dat;
  logic [7:0] mem [256];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (pl_we) mem[pl_addr] <= pl_dat;
    ram_rdata <= mem[ram_addr];
  end

  ram_arbiter #(.AW(8), .DW(8), .MAX_WAIT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    pl_we = 1; pl_addr = 8'h0F; pl_dat = 8'hA5;
    tick();
    pl_addr = 8'h10; pl_dat = 8'h77;
    tick();
    pl_addr = 8'h11; pl_dat = 8'h88;
    tick();
    pl_we = 0;
    tests++;
    if ({gnt0, gnt1, ack0, ack1, ram_we, busy} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, ack0, ack1, ram_we, busy});
    end
    tests++;
    if (ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_ram_bus: addr %h wdata %h want 00 00", ram_addr, ram_wdata);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_read0();
    req0 = 1; we0 = 0; addr0 = 8'h0F;
    tick();
    req0 = 0;
    tests++;
    if ({gnt0, gnt1, ack0, busy, ram_we} !== 5'b10010 || ram_addr !== 8'h0F) begin
      fails++;
      $display("FAIL rd0_access: g0g1a0busywe %b addr %h want 10010 0f",
               {gnt0, gnt1, ack0, busy, ram_we}, ram_addr);
    end
    tick();
    tests++;
    if ({gnt0, ack0, ack1, ram_we} !== 4'b1100 || rdata0 !== 8'hA5) begin
      fails++;
      $display("FAIL rd0_resp: g0a0a1we %b rdata0 %h want 1100 a5", {gnt0, ack0, ack1, ram_we}, rdata0);
    end
    tick();
    tests++;
    if ({gnt0, ack0, busy} !== 3'b000 || rdata0 !== 8'hA5) begin
      fails++;
      $display("FAIL rd0_idle_hold: g0a0busy %b rdata0 %h want 000 a5", {gnt0, ack0, busy}, rdata0);
    end
  endtask

  task automatic test_write_read1();
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
    tick();
    tests++;
    if ({gnt1, gnt0, ram_we} !== 3'b101 || ram_addr !== 8'h20 || ram_wdata !== 8'h3C) begin
      fails++;
      $display("FAIL wr1_access: g1g0we %b addr %h wdata %h want 101 20 3c",
               {gnt1, gnt0, ram_we}, ram_addr, ram_wdata);
    end
    we1 = 0;
    tick();
    tests++;
    if ({gnt1, ack1, ram_we} !== 3'b110) begin
      fails++;
      $display("FAIL wr1_resp: g1a1we %b want 110", {gnt1, ack1, ram_we});
    end
    tick();
    req1 = 0;
    tests++;
    if ({gnt1, ack1, ram_we} !== 3'b100 || ram_addr !== 8'h20) begin
      fails++;
      $display("FAIL rd1_access: g1a1we %b addr %h want 100 20", {gnt1, ack1, ram_we}, ram_addr);
    end
    tick();
    tests++;
    if (ack1 !== 1'b1 || rdata1 !== 8'h3C) begin
      fails++;
      $display("FAIL rd1_resp: ack1 %b rdata1 %h want 1 3c", ack1, rdata1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] order;
    order = 6'b100100;
    req0 = 1; we0 = 0; addr0 = 8'h0F;
    req1 = 1; we1 = 0; addr1 = 8'h10;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (gnt1 !== order[i] || gnt0 !== !order[i] || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        fails++;
        $display("FAIL b2b_grant%0d: g0 %b g1 %b a0 %b a1 %b want g1=%b no ack",
                 i, gnt0, gnt1, ack0, ack1, order[i]);
      end
      if (i == 5) begin
        req0 = 0;
        req1 = 0;
      end
      tick();
      tests++;
      if (order[i] ? (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata1 !== 8'h77)
                   : (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata0 !== 8'hA5)) begin
        fails++;
        $display("FAIL b2b_ack%0d: a0 %b a1 %b rd0 %h rd1 %h want owner=%0d (a5/77)",
                 i, ack0, ack1, rdata0, rdata1, order[i]);
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: busy %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1; we0 = 0; addr0 = 8'h10;
    tick();
    req0 = 0;
    reset_n = 0;
    tests++;
    if (gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_access: gnt0 %b want 1", gnt0);
    end
    tick();
    reset_n = 1;
    tests++;
    if ({gnt0, ack0, busy} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid_abort: g0a0busy %b want 000", {gnt0, ack0, busy});
    end
    tick();
    tests++;
    if ({ack0, busy} !== 2'b00) begin
      fails++;
      $display("FAIL rst_mid_noack: a0busy %b want 00", {ack0, busy});
    end
    req0 = 1; addr0 = 8'h11;
    tick();
    req0 = 0;
    tick();
    tests++;
    if (ack0 !== 1'b1 || rdata0 !== 8'h88) begin
      fails++;
      $display("FAIL rst_mid_reread: ack0 %b rdata0 %h want 1 88", ack0, rdata0);
    end
    tick();
  endtask

  task automatic test_attr_change();
    req1 = 1; we1 = 0; addr1 = 8'h10;
    tick();
    addr1 = 8'h11;
    req1 = 0;
    tests++;
    if (ram_addr !== 8'h10 || gnt1 !== 1'b1) begin
      fails++;
      $display("FAIL attr_access: addr %h gnt1 %b want 10 1", ram_addr, gnt1);
    end
    tick();
    tests++;
    if (ack1 !== 1'b1 || rdata1 !== 8'h77 || ram_addr !== 8'h10) begin
      fails++;
      $display("FAIL attr_resp: ack1 %b rdata1 %h addr %h want 1 77 10", ack1, rdata1, ram_addr);
    end
    tick();
    tests++;
    if (ram_addr !== 8'h10 || rdata1 !== 8'h77 || busy !== 1'b0) begin
      fails++;
      $display("FAIL attr_idle_hold: addr %h rdata1 %h busy %b want 10 77 0", ram_addr, rdata1, busy);
    end
  endtask

  initial begin
    test_reset();
    test_read0();
    test_write_read1();
    test_back_to_back();
    test_reset_mid();
    test_attr_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
